wtime_calc: RTL and testbench

Parametrised successor to the queue wait-time lookup. It computes the estimated waiting time wtime = TSERV*(pcount + tcount - 1)/tcount from the queue's people count and the active-teller count. An iterative restoring divider replaces the fixed lookup table, so the width of pcount, the width of tcount and the per-customer service time are all free parameters. It sits between the people/teller counters and the display/decoder stage, and uses a valid/ready request handshake with a done pulse.

---
 rtl/wtime_if.sv | 25 ++
 rtl/wtime_calc.sv | 129 ++++++++++++
 tb/tb_wtime_calc.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/wtime_if.sv
// Request/result bundle for wtime_calc: valid/ready request carrying the
// queue and teller counts, plus the waiting-time result with its done pulse.
interface wtime_if #(
  parameter int N  = 3,
  parameter int T  = 2,
  parameter int WW = 5
);
  logic          req_valid;
  logic          req_ready;
  logic [N-1:0]  pcount;
  logic [T-1:0]  tcount;
  logic [WW-1:0] wtime;
  logic          done;
  logic          busy;

  modport master (
    output req_valid, pcount, tcount,
    input  req_ready, wtime, done, busy
  );

  modport slave (
    input  req_valid, pcount, tcount,
    output req_ready, wtime, done, busy
  );
endinterface

// File: rtl/wtime_calc.sv
// Waiting-time estimator: wtime = TSERV*(pcount+tcount-1)/tcount via an iterative
// restoring divider. Optional macro WTIME_AUTO_EN self-issues requests on input change.
module wtime_calc #(
  parameter int N     = 3,
  parameter int T     = 2,
  parameter int TSERV = 3,
  parameter int WW    = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  wtime_if.slave bus
);
  localparam int NW = N + T + 4;
  localparam int CW = $clog2(NW);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

  state_e          state_q, state_d;
  logic [T-1:0]    t_q, t_d;
  logic [NW-1:0]   num_q, num_d;   // numerator, quotient bits shift in at the LSB
  logic [T:0]      rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wtime_q, wtime_d;
  logic            done_q, done_d;
`ifdef WTIME_AUTO_EN
  logic [N-1:0]    p_q, p_d;
  logic            first_q, first_d;
`endif

  logic            start;
  logic [N+T-1:0]  sum;
  logic [NW-1:0]   prod;
  logic [T:0]      rem_sh;
  logic            qbit;
  logic [NW+WW-1:0] quo_ext;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    num_d   = num_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    wtime_d = wtime_q;
    done_d  = 1'b0;
`ifdef WTIME_AUTO_EN
    p_d     = p_q;
    first_d = first_q;
    start   = (state_q == IDLE) &&
              (bus.req_valid || first_q || ({bus.tcount, bus.pcount} != {t_q, p_q}));
`else
    start   = (state_q == IDLE) && bus.req_valid;
`endif

    // t >= 1 whenever this feeds the divider, so the subtraction never wraps
    sum     = {{T{1'b0}}, bus.pcount} + {{N{1'b0}}, bus.tcount} - (N+T)'(1);
    prod    = NW'(TSERV) * {{(NW-N-T){1'b0}}, sum};
    rem_sh  = {rem_q[T-1:0], num_q[NW-1]};
    qbit    = (rem_sh >= {1'b0, t_q});
    quo_ext = {{WW{1'b0}}, num_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          t_d   = bus.tcount;
          rem_d = '0;
          cnt_d = CW'(NW-1);
`ifdef WTIME_AUTO_EN
          p_d     = bus.pcount;
          first_d = 1'b0;
`endif
          if (bus.tcount == '0) begin
            num_d   = '0;
            state_d = DONE;
          end else begin
            num_d   = prod;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = qbit ? (rem_sh - {1'b0, t_q}) : rem_sh;
        num_d = {num_q[NW-2:0], qbit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        wtime_d = (|(quo_ext >> WW)) ? '1 : quo_ext[WW-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      wtime_q <= '0;
      done_q  <= 1'b0;
`ifdef WTIME_AUTO_EN
      p_q     <= '0;
      first_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      wtime_q <= wtime_d;
      done_q  <= done_d;
`ifdef WTIME_AUTO_EN
      p_q     <= p_d;
      first_q <= first_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == DIV);
  assign bus.wtime     = wtime_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_wtime_calc.sv
// Self-checking bench for wtime_calc: a default-width instance and a WW=4 instance
// share stimulus; results are compared against an arithmetic reference model.
module tb_wtime_calc;
  localparam int N = 3, T = 2, TSERV = 3, WW = 5, WWS = 4;
  localparam int NW = N + T + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wtime_if #(.N(N), .T(T), .WW(WW))  bus0 ();
  wtime_if #(.N(N), .T(T), .WW(WWS)) bus1 ();

  assign bus1.req_valid = bus0.req_valid;
  assign bus1.pcount    = bus0.pcount;
  assign bus1.tcount    = bus0.tcount;

  wtime_calc #(.N(N), .T(T), .TSERV(TSERV), .WW(WW)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  wtime_calc #(.N(N), .T(T), .TSERV(TSERV), .WW(WWS)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: floor(TSERV*(p+t-1)/t), zero when no teller, clipped to the output width.
  function automatic int ref_wt(input int p, input int t, input int ww);
    int q;
    if (t == 0) return 0;
    q = (TSERV * (p + t - 1)) / t;
    if (q > (1 << ww) - 1) q = (1 << ww) - 1;
    return q;
  endfunction

  task automatic run_req(input int p, input int t);
    int lat, busyc;
    @(negedge clk);
    check("ready_idle", 32'(bus0.req_ready), 1);
    bus0.pcount = N'(p); bus0.tcount = T'(t); bus0.req_valid = 1'b1;
    @(negedge clk);
    bus0.req_valid = 1'b0;
    bus0.pcount = N'($urandom); bus0.tcount = T'($urandom);
    lat = 0;
    busyc = bus0.busy ? 1 : 0;
    for (int j = 1; j <= NW + 6; j++) begin
      @(negedge clk);
      if (lat == 0) begin
        if (bus0.done) begin
          lat = j;
          check("wtime", 32'(bus0.wtime), 32'(ref_wt(p, t, WW)));
          check("wtime_sat", 32'(bus1.wtime), 32'(ref_wt(p, t, WWS)));
          check("done_sat", 32'(bus1.done), 1);
        end else if (bus0.busy) busyc++;
      end else if (j == lat + 1) begin
        check("done_pulse_width", 32'(bus0.done), 0);
      end
    end
    check("latency", 32'(lat), (t == 0) ? 1 : NW + 1);
    check("busy_cycles", 32'(busyc), (t == 0) ? 0 : NW);
  endtask

`ifdef WTIME_AUTO_EN
  task automatic wait_results(input int cycles, input int exp_cnt, input int exp_wt);
    int cnt;
    cnt = 0;
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      if (bus0.done) begin
        cnt++;
        check("auto_wtime", 32'(bus0.wtime), 32'(exp_wt));
      end
    end
    check("auto_done_count", 32'(cnt), 32'(exp_cnt));
  endtask
`endif

  initial begin
    bus0.req_valid = 1'b0;
    bus0.pcount = '0;
    bus0.tcount = '0;
`ifdef WTIME_AUTO_EN
    bus0.pcount = 3'd3;
    bus0.tcount = 2'd1;
    #1;
    check("rst_wtime", 32'(bus0.wtime), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_results(4 * NW, 1, ref_wt(3, 1, WW));
    bus0.pcount = 3'd4;
    wait_results(4 * NW, 1, ref_wt(4, 1, WW));
    wait_results(3 * (NW + 2), 0, 0);
`else
    #1;
    check("rst_wtime", 32'(bus0.wtime), 0);
    check("rst_done", 32'(bus0.done), 0);
    check("rst_busy", 32'(bus0.busy), 0);
    check("rst_ready", 32'(bus0.req_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_req(5, 2);
    run_req(7, 1);
    run_req(7, 3);
    run_req(0, 1);
    for (int i = 0; i < 12; i++) run_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    run_req(5, 2);

    // t==0 with req_valid held: done at k+1, second accept at k+2
    @(negedge clk);
    bus0.pcount = 3'd6; bus0.tcount = 2'd0; bus0.req_valid = 1'b1;
    @(negedge clk);
    check("t0_ready_in_done", 32'(bus0.req_ready), 0);
    @(negedge clk);
    check("t0_done", 32'(bus0.done), 1);
    check("t0_wtime", 32'(bus0.wtime), 0);
    @(negedge clk);
    check("t0_second_accept", 32'(bus0.done), 0);
    @(negedge clk);
    check("t0_second_done", 32'(bus0.done), 1);

    // held request with t!=0: next accept only once the result has been delivered
    bus0.pcount = 3'd5; bus0.tcount = 2'd2;
    for (int j = 0; j <= NW + 2; j++) begin
      @(negedge clk);
      if (j == NW + 1) begin
        check("held_done", 32'(bus0.done), 1);
        check("held_ready", 32'(bus0.req_ready), 1);
      end
      if (j == NW + 2) check("held_reaccept_busy", 32'(bus0.busy), 1);
    end
    bus0.req_valid = 1'b0;
    repeat (NW + 3) @(negedge clk);
    check("pre_abort_wtime", 32'(bus0.wtime), 32'(ref_wt(5, 2, WW)));

    // reset in the middle of a division
    bus0.pcount = 3'd7; bus0.tcount = 2'd3; bus0.req_valid = 1'b1;
    @(negedge clk);
    bus0.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_wtime", 32'(bus0.wtime), 0);
    check("abort_busy", 32'(bus0.busy), 0);
    check("abort_ready", 32'(bus0.req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int dcnt;
      dcnt = 0;
      for (int j = 0; j < NW + 4; j++) begin
        @(negedge clk);
        if (bus0.done) dcnt++;
      end
      check("abort_no_done", 32'(dcnt), 0);
      check("abort_ready_after", 32'(bus0.req_ready), 1);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
